cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Common Data Bus arbiter and broadcast register for the execution pipeline. It is the responder side of the unit-to-CDB handshake. Each execution unit (branch unit, ALUs, load/store, mult/div) presents a completed result with `valid`. The arbiter grants one requestor per cycle with `ready`, registers the winning `cdb_data_t`, and broadcasts it to all reservation stations and to the ROB. The arbiter sits between the execution units and the ROB write port.

## Interface
Parameters:
- `N_UNITS`, default 4: number of requesting units; must be ≥1. Index 0 is the branch unit.
- `PTR_LEN`, default `$clog2(N_UNITS)` (1 when `N_UNITS`=1): width of the round-robin pointer.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `flush_i`, in, 1: pipeline flush (mispredict or exception).
- `valid_i`, in, `N_UNITS`: per-unit result-valid request.
- `data_i`, in, `N_UNITS` x `cdb_data_t`: per-unit result.
- `ready_o`, out, `N_UNITS`: per-unit grant. At most one bit is set.
- `rob_ready_i`, in, 1: ROB accepts the current CDB beat.
- `cdb_valid_o`, out, 1: the CDB carries a valid result.
- `cdb_data_o`, out, `cdb_data_t`: broadcast result.

## Operation
- One-entry output register: `cdb_valid_o` / `cdb_data_o`.
- Load enable: `load = ~flush_i & (~cdb_valid_o | rob_ready_i)`.
- When `load` is asserted and any `valid_i` bit is set:
  - Pick the first set bit at or after pointer `ptr`, wrapping modulo `N_UNITS`. Call it `g`.
  - Drive `ready_o` one-hot at `g`.
  - Register `data_i[g]`.
  - Set `cdb_valid_o` = 1.
  - Update `ptr` to `(g+1) mod N_UNITS`.
- When `load` is asserted and no `valid_i` bit is set: `cdb_valid_o` goes to 0 on the next edge; `ptr` and `cdb_data_o` hold.
- When `load` is deasserted (ROB stall): `ready_o` = 0; the register and `ptr` hold.
- `flush_i` takes priority over everything:
  - `ready_o` = 0 in the flush cycle.
  - `cdb_valid_o` = 0 on the next edge.
  - `ptr` holds.
  - `cdb_data_o` holds its stale value.
- A unit transfers its result only on a cycle with `valid_i[k] & ready_o[k]`. Units must not make `valid_i` depend on `ready_o`.
- `ready_o` is combinational from `valid_i`, `ptr`, `cdb_valid_o`, `rob_ready_i` and `flush_i`.
- When `N_UNITS`=1, `ptr` is constant 0 and the block degenerates to a pipeline register with handshake.

## Timing
- Reset values while `rst_i`=1, applied asynchronously:
  - `cdb_valid_o` = 0.
  - `cdb_data_o` = '0.
  - `ptr` = 0.
  - `ready_o` forced to 0.
- Latency: a grant in cycle t appears on `cdb_valid_o` / `cdb_data_o` in cycle t+1.
- Throughput: one result per cycle while `rob_ready_i`=1.
- Simultaneous consume and grant: in a cycle where `cdb_valid_o`=1 and `rob_ready_i`=1, the next winner is loaded in the same cycle with no bubble.
- Simultaneous `flush_i` and `rob_ready_i`: the current beat counts as consumed, and nothing new is loaded.
- Reset deasserted mid-traffic: the first grant may occur in the first cycle after release, starting from `ptr` = 0.

## Configuration
- `CDB_ARB_BRANCH_PRIO_EN` defined:
  - Unit 0 (branch) wins whenever `valid_i[0]`=1, regardless of `ptr`; `ptr` is not updated on such grants.
  - All other grants are round-robin over units 1..`N_UNITS`-1 as above.
  - Purpose: shortens mispredict resolution.
- `CDB_ARB_BRANCH_PRIO_EN` undefined: pure round-robin over all `N_UNITS`, with unit 0 treated like any other unit.

## Structure
- `cdb_data_t` stays in `expipe_pkg`.
- Add to `expipe_pkg`:
  - `CDB_N_UNITS`.
  - Unit index constants `CDB_IDX_BU` = 0, `CDB_IDX_ALU`, `CDB_IDX_LSU`, `CDB_IDX_MULT`.
- One sub-module, `rr_arbiter`:
  - Parameterised by `N`.
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and grant index.
  - Combinational only.
- `cdb_arbiter` owns `ptr`, the output register, the flush logic and the macro-controlled priority override.

## Test plan
Benches use `N_UNITS`=4.
- Reset: `rst_i`=1 with `valid_i`=4'b1111 → `ready_o`=4'b0000, `cdb_valid_o`=0; after release, the first grant goes to unit 0.
- Round-robin: `valid_i`=4'b1111 held for 4 cycles, `rob_ready_i`=1, macro undefined → grants 0,1,2,3; `cdb_data_o.rob_idx` equals `data_i[g].rob_idx` one cycle after each grant; `ptr` wraps to 0.
- Wrap: `ptr`=3 and `valid_i`=4'b0010 → `ready_o`=4'b0010 in the same cycle, and `ptr` becomes 2.
- Stall: `cdb_valid_o`=1, `rob_ready_i`=0, `valid_i`=4'b0100 for 3 cycles → `ready_o`=0 and `cdb_data_o` stable. When `rob_ready_i` rises, `ready_o`=4'b0100 in that cycle and the new data appears the next cycle.
- Flush: `cdb_valid_o`=1 and `valid_i`=4'b1010 with `flush_i`=1 for one cycle → `ready_o`=0, and `cdb_valid_o`=0 on the next cycle.
- Priority macro: `valid_i`=4'b0101 held for 4 cycles → with `CDB_ARB_BRANCH_PRIO_EN`, grants are 0,0,0,0; without it, grants are 0,2,0,2.

Source files
------------

// File: rtl/expipe_pkg.sv
// Shared execution-pipeline types: the CDB result beat and the CDB unit map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package expipe_pkg;

  // Result beat broadcast on the Common Data Bus.
  typedef struct packed {
    logic [5:0]  rob_idx;  // ROB entry being completed
    logic [31:0] value;    // result value
    logic        exc;      // result raised an exception
  } cdb_data_t;

  // Requestor map of the CDB arbiter. The branch unit must stay at index 0.
  localparam int CDB_N_UNITS  = 4;
  localparam int CDB_IDX_BU   = 0;
  localparam int CDB_IDX_ALU  = 1;
  localparam int CDB_IDX_LSU  = 2;
  localparam int CDB_IDX_MULT = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: lowest requesting index at or after ptr_i, wrapping to the lowest overall.
// Latency: purely combinational, zero cycles.
// Backpressure: en_i low forces gnt_o to zero and any_o low.
// Ports: req_i request vector, ptr_i search start, en_i grant enable,
//        gnt_o one-hot grant, idx_o grant index, any_o a grant was made.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    // Wrap-around candidate: lowest requester overall.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = PW'(i);
        any_o = 1'b1;
      end
    end
    // Preferred candidate: lowest requester at or after the pointer overrides the wrap choice.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i] && (i >= int'(ptr_i))) begin
        idx_o = PW'(i);
      end
    end
    if (!en_i) begin
      any_o = 1'b0;
    end
    if (any_o) begin
      gnt_o = N'(1) << idx_o;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants one execution unit per cycle and registers its result for broadcast.
// Latency: a grant in cycle t is on cdb_valid_o/cdb_data_o in cycle t+1; one beat per cycle.
// Backpressure: ready_o drops while the held beat is not taken by the ROB (rob_ready_i=0) or on flush.
// Ports: clk_i, rst_i (async, active-high), flush_i, valid_i/data_i/ready_o per unit,
//        rob_ready_i from the ROB, cdb_valid_o/cdb_data_o broadcast.
// Build option: CDB_ARB_BRANCH_PRIO_EN gives unit 0 (branch) absolute priority without moving the pointer.
module cdb_arbiter
  import expipe_pkg::*;
#(
  parameter int N_UNITS = CDB_N_UNITS,
  parameter int PTR_LEN = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic [N_UNITS-1:0] valid_i,
  input  cdb_data_t          data_i [N_UNITS],
  output logic [N_UNITS-1:0] ready_o,
  input  logic               rob_ready_i,
  output logic               cdb_valid_o,
  output cdb_data_t          cdb_data_o
);

  logic               cdb_valid_q, cdb_valid_d;
  cdb_data_t          cdb_data_q, cdb_data_d;
  logic [PTR_LEN-1:0] ptr_q, ptr_d;

  logic               load;
  logic [N_UNITS-1:0] rr_req;
  logic [N_UNITS-1:0] rr_gnt;
  logic [PTR_LEN-1:0] rr_idx;
  logic               rr_any;
  logic [PTR_LEN-1:0] win_idx;
  logic               win_any;
  logic               bump_ptr;

  // Output register may take a new beat when empty or being drained this cycle.
  // Reset is folded in so ready_o is held low while rst_i is high.
  assign load = ~rst_i & ~flush_i & (~cdb_valid_q | rob_ready_i);

  always_comb begin
    rr_req = valid_i;
`ifdef CDB_ARB_BRANCH_PRIO_EN
    // Branch unit is served by the override below, never by the rotation.
    rr_req[0] = 1'b0;
`endif
  end

  rr_arbiter #(
    .N  (N_UNITS),
    .PW (PTR_LEN)
  ) u_rr (
    .req_i (rr_req),
    .ptr_i (ptr_q),
    .en_i  (load),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  always_comb begin
    ready_o  = rr_gnt;
    win_idx  = rr_idx;
    win_any  = rr_any;
    bump_ptr = rr_any;
`ifdef CDB_ARB_BRANCH_PRIO_EN
    if (load && valid_i[0]) begin
      ready_o    = '0;
      ready_o[0] = 1'b1;
      win_idx    = '0;
      win_any    = 1'b1;
      bump_ptr   = 1'b0;
    end
`endif

    cdb_valid_d = cdb_valid_q;
    cdb_data_d  = cdb_data_q;
    ptr_d       = ptr_q;
    if (flush_i) begin
      // Current beat is dropped (or counts as consumed); stale data is left in place.
      cdb_valid_d = 1'b0;
    end else if (load) begin
      cdb_valid_d = win_any;
      if (win_any) begin
        cdb_data_d = data_i[win_idx];
      end
    end
    if (bump_ptr) begin
      ptr_d = (win_idx == PTR_LEN'(N_UNITS - 1)) ? '0 : win_idx + PTR_LEN'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      ptr_q       <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      ptr_q       <= ptr_d;
    end
  end

  assign cdb_valid_o = cdb_valid_q;
  assign cdb_data_o  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter with four units: directed vectors, a reference model, per-cycle compare.
// Latency: n/a.
// Backpressure: exercised through rob_ready_i stalls and flush.
module tb_cdb_arbiter;
  import expipe_pkg::*;

  localparam int N = 4;

  logic            clk_i;
  logic            rst_i;
  logic            flush_i;
  logic [N-1:0]    valid_i;
  cdb_data_t       data_i [N];
  logic [N-1:0]    ready_o;
  logic            rob_ready_i;
  logic            cdb_valid_o;
  cdb_data_t       cdb_data_o;

  int n_chk  = 0;
  int n_fail = 0;
  int seq    = 0;

  cdb_arbiter #(.N_UNITS(N)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .rob_ready_i (rob_ready_i),
    .cdb_valid_o (cdb_valid_o),
    .cdb_data_o  (cdb_data_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // ---------------- reference model ----------------
  logic      m_valid;
  cdb_data_t m_data;
  int        m_ptr;

  // Winner among requesters by the arbitration rules, or -1.
  function automatic int model_pick(input logic [N-1:0] v, input int p);
`ifdef CDB_ARB_BRANCH_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int j = 0; j < N; j++) begin
      int k;
      k = (p + j) % N;
`ifdef CDB_ARB_BRANCH_PRIO_EN
      if (k == 0) continue;
`endif
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic model_load();
    return !rst_i && !flush_i && (!m_valid || rob_ready_i);
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = model_pick(valid_i, m_ptr);
    if (model_load() && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    int g;
    if (rst_i) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ptr   <= 0;
    end else if (flush_i) begin
      m_valid <= 1'b0;
    end else if (model_load()) begin
      g = model_pick(valid_i, m_ptr);
      if (g >= 0) begin
        m_valid <= 1'b1;
        m_data  <= data_i[g];
`ifdef CDB_ARB_BRANCH_PRIO_EN
        if (g != 0) m_ptr <= (g + 1) % N;
`else
        m_ptr <= (g + 1) % N;
`endif
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk_i) begin
    logic [N-1:0] er;
    er = model_ready();
    n_chk++;
    if (ready_o !== er) begin
      n_fail++;
      $display("FAIL model_ready t=%0t: got %b expected %b", $time, ready_o, er);
    end
    n_chk++;
    if (cdb_valid_o !== m_valid) begin
      n_fail++;
      $display("FAIL model_cdb_valid t=%0t: got %b expected %b", $time, cdb_valid_o, m_valid);
    end
    n_chk++;
    if (cdb_data_o !== m_data) begin
      n_fail++;
      $display("FAIL model_cdb_data t=%0t: got %h expected %h", $time, cdb_data_o, m_data);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic new_data();
    for (int k = 0; k < N; k++) begin
      data_i[k].rob_idx = 6'((seq * N + k) % 64);
      data_i[k].value   = $urandom;
      data_i[k].exc     = 1'($urandom_range(0, 1));
    end
    seq++;
  endtask

  // Advance one clock; inputs change 1 time unit after the edge, then settle 1 more.
  task automatic cyc();
    @(posedge clk_i);
    #1;
    new_data();
  endtask

  initial begin
    logic [N-1:0] rr_exp [4];
    logic [N-1:0] pr_exp [4];
    cdb_data_t    held;
    logic [5:0]   exp_idx;

`ifdef CDB_ARB_BRANCH_PRIO_EN
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
    pr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    pr_exp = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
`endif

    // Reset with all units requesting.
    rst_i = 1'b1; flush_i = 1'b0; rob_ready_i = 1'b1; valid_i = 4'b1111;
    new_data();
    #2;
    lit("reset_ready", 64'(ready_o), 64'h0);
    lit("reset_cdb_valid", 64'(cdb_valid_o), 64'h0);
    lit("reset_cdb_data", 64'(cdb_data_o), 64'h0);
    cyc(); cyc();
    rst_i = 1'b0;
    #1;

    // Round robin, all four requesting; data checked one cycle after each grant.
    for (int i = 0; i < 4; i++) begin
      lit($sformatf("rr_grant%0d", i), 64'(ready_o), 64'(rr_exp[i]));
      exp_idx = data_i[(i == 0 || rr_exp[i] == 4'b0001) ? 0 : i].rob_idx;
      cyc();
      #1;
      lit($sformatf("rr_rob_idx%0d", i), 64'(cdb_data_o.rob_idx), 64'(exp_idx));
      lit($sformatf("rr_valid%0d", i), 64'(cdb_valid_o), 64'h1);
    end

    // Move pointer to 3, then wrap: only unit 1 requests.
    valid_i = 4'b0100; #1;
    lit("to_ptr3", 64'(ready_o), 64'b0100);
    cyc();
    valid_i = 4'b0010; #1;
    lit("wrap_grant", 64'(ready_o), 64'b0010);
    cyc();
    valid_i = 4'b1111; #1;
`ifdef CDB_ARB_BRANCH_PRIO_EN
    lit("ptr_after_wrap", 64'(ready_o), 64'b0001);
`else
    lit("ptr_after_wrap", 64'(ready_o), 64'b0100);
`endif
    cyc();

    // ROB stall with a held beat.
    rob_ready_i = 1'b0; valid_i = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      held = cdb_data_o;
      lit($sformatf("stall_ready%0d", i), 64'(ready_o), 64'h0);
      cyc();
      #1;
      lit($sformatf("stall_hold%0d", i), 64'(cdb_data_o), 64'(held));
    end
    rob_ready_i = 1'b1; #1;
    lit("stall_release_ready", 64'(ready_o), 64'b0100);
    held = data_i[2];
    cyc(); #1;
    lit("stall_release_data", 64'(cdb_data_o), 64'(held));

    // Flush while a beat is held and the ROB is ready.
    valid_i = 4'b1010; flush_i = 1'b1; #1;
    lit("flush_ready", 64'(ready_o), 64'h0);
    cyc(); #1;
    lit("flush_valid_next", 64'(cdb_valid_o), 64'h0);
    flush_i = 1'b0; valid_i = 4'b0000;
    cyc(); #1;
    lit("idle_valid", 64'(cdb_valid_o), 64'h0);

    // Branch unit plus LSU requesting continuously.
    valid_i = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      #1;
      lit($sformatf("prio_grant%0d", i), 64'(ready_o), 64'(pr_exp[i]));
      cyc();
    end

    // Reset asserted mid-traffic, then released.
    valid_i = 4'b1111;
    rst_i = 1'b1; #1;
    lit("midreset_ready", 64'(ready_o), 64'h0);
    lit("midreset_valid", 64'(cdb_valid_o), 64'h0);
    cyc();
    rst_i = 1'b0; #1;
    lit("post_reset_first", 64'(ready_o), 64'b0001);
    cyc(); cyc();
    valid_i = 4'b0000;
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
